adc_sram_fifo_ctrl: RTL and testbench



---
 rtl/adc_sram_fifo_ctrl_if.sv | 12 +
 rtl/adc_sram_fifo_ctrl.sv | 148 ++++++++++++++
 tb/tb_adc_sram_fifo_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_sram_fifo_ctrl_if.sv
// Consumer-side valid/ready stream of the ADC sample FIFO.
// master = FIFO controller (source), slave = downstream consumer (sink).
interface adc_sram_fifo_ctrl_if #(
    parameter int unsigned DW = 12
);
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/adc_sram_fifo_ctrl.sv
// FWFT FIFO controller sequencing a 1-cycle-latency two-port SRAM, with a 2-entry output skid.
// Optional ADC_FIFO_OVF_CNT_EN adds an 8-bit saturating dropped-sample counter (ovf_cnt).
module adc_sram_fifo_ctrl #(
    parameter int unsigned DW = 12,
    parameter int unsigned AW = 4
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic [DW-1:0]         sample_in,
    input  logic                  sample_valid,
    input  logic                  flush,
    input  logic                  clr_ovf,
    adc_sram_fifo_ctrl_if.master  out_if,
    output logic [AW:0]           level,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic [DW-1:0]         ram_wd,
    output logic [AW-1:0]         ram_waddr,
    output logic                  ram_wen,
    output logic [AW-1:0]         ram_raddr,
    input  logic [DW-1:0]         ram_rd
`ifdef ADC_FIFO_OVF_CNT_EN
    ,
    output logic [7:0]            ovf_cnt
`endif
);

    localparam logic [AW:0] Depth = (AW+1)'(1 << AW);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic [DW-1:0] skid_q [2];
    logic [DW-1:0] skid_d [2];
    logic [1:0]    skid_cnt_q, skid_cnt_d;
    logic          skid_head_q, skid_head_d;
    logic          inflight_q, inflight_d;
    logic          ovf_q, ovf_d;

    logic          push, drop, pop, fetch, out_valid;
    logic [2:0]    occ;

    always_comb begin
        full      = (level_q == Depth);
        out_valid = (skid_cnt_q != 2'd0);
        empty     = (level_q == '0) && !out_valid;
        pop       = out_valid && out_if.out_ready;
        push      = sample_valid && !full && !flush;
        drop      = sample_valid && full && !flush;
        occ       = {1'b0, skid_cnt_q} + {2'b00, inflight_q};
        // Only fetch if the skid has room for the word once everything in flight lands.
        fetch     = !flush && (level_q != '0) && ((occ - {2'b00, pop}) < 3'd2);

        ram_wen   = push;
        ram_waddr = wptr_q;
        ram_wd    = push ? sample_in : '0;
        ram_raddr = rptr_q;

        level     = level_q;
        overflow  = ovf_q;
        out_if.out_valid = out_valid;
        out_if.out_data  = skid_q[skid_head_q];
    end

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        skid_d      = skid_q;
        skid_cnt_d  = skid_cnt_q;
        skid_head_d = skid_head_q;
        inflight_d  = inflight_q;
        ovf_d       = drop | (ovf_q & ~clr_ovf);

        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            level_d     = '0;
            skid_cnt_d  = 2'd0;
            skid_head_d = 1'b0;
            inflight_d  = 1'b0;
        end else begin
            wptr_d     = wptr_q + AW'(push);
            rptr_d     = rptr_q + AW'(fetch);
            level_d    = level_q + (AW+1)'(push) - (AW+1)'(fetch);
            inflight_d = fetch;
            if (inflight_q) begin
                skid_d[skid_head_q ^ skid_cnt_q[0]] = ram_rd;
            end
            if (pop) begin
                skid_head_d = ~skid_head_q;
            end
            skid_cnt_d = skid_cnt_q + 2'(inflight_q) - 2'(pop);
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            skid_q[0]   <= '0;
            skid_q[1]   <= '0;
            skid_cnt_q  <= 2'd0;
            skid_head_q <= 1'b0;
            inflight_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            skid_q[0]   <= skid_d[0];
            skid_q[1]   <= skid_d[1];
            skid_cnt_q  <= skid_cnt_d;
            skid_head_q <= skid_head_d;
            inflight_q  <= inflight_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef ADC_FIFO_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (drop) begin
            if (clr_ovf) begin
                ovf_cnt_d = 8'd1;
            end else if (ovf_cnt_q != 8'hFF) begin
                ovf_cnt_d = ovf_cnt_q + 8'd1;
            end
        end else if (clr_ovf) begin
            ovf_cnt_d = 8'd0;
        end
        ovf_cnt = ovf_cnt_q;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ovf_cnt_q <= 8'd0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_adc_sram_fifo_ctrl.sv
// Scoreboard bench for adc_sram_fifo_ctrl with a behavioural 1-cycle-latency SRAM.
// Honours ADC_FIFO_OVF_CNT_EN when defined.
module tb_adc_sram_fifo_ctrl;

    localparam int unsigned DW = 12;
    localparam int unsigned AW = 4;

    logic          CLK = 1'b0;
    logic          RESETN;
    logic [DW-1:0] sample_in;
    logic          sample_valid;
    logic          flush;
    logic          clr_ovf;
    logic [AW:0]   level;
    logic          full, empty, overflow;
    logic [DW-1:0] ram_wd, ram_rd;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic          ram_wen;
`ifdef ADC_FIFO_OVF_CNT_EN
    logic [7:0]    ovf_cnt;
`endif

    adc_sram_fifo_ctrl_if #(.DW(DW)) out_if ();

    adc_sram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .flush        (flush),
        .clr_ovf      (clr_ovf),
        .out_if       (out_if.master),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .ram_wd       (ram_wd),
        .ram_waddr    (ram_waddr),
        .ram_wen      (ram_wen),
        .ram_raddr    (ram_raddr),
        .ram_rd       (ram_rd)
`ifdef ADC_FIFO_OVF_CNT_EN
        ,
        .ovf_cnt      (ovf_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] mem [16];
    always @(posedge CLK) begin
        if (ram_wen) mem[ram_waddr] <= ram_wd;
        ram_rd <= mem[ram_raddr];
    end

    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops compared against the scoreboard, stall stability enforced.
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    always @(negedge CLK) begin
        if (RESETN) begin
            if (stall_prev) begin
                chk("stall_valid", 32'(out_if.out_valid), 32'd1);
                chk("stall_data", 32'(out_if.out_data), 32'(prev_data));
            end
            if (out_if.out_valid && out_if.out_ready) begin
                chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("pop_data", 32'(out_if.out_data), 32'(exp_q.pop_front()));
            end
            stall_prev = out_if.out_valid && !out_if.out_ready && !flush;
            prev_data  = out_if.out_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic accept);
        sample_valid = v;
        sample_in    = d;
        if (v && accept) exp_q.push_back(d);
    endtask

    task automatic drain(input string tag);
        out_if.out_ready = 1'b1;
        sample_valid     = 1'b0;
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick();
        repeat (3) tick();
        @(negedge CLK);
        #1;
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_nvalid"}, 32'(out_if.out_valid), 32'd0);
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, 32'(out_if.out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(out_if.out_data), 32'd0);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_ram_wen"}, 32'(ram_wen), 32'd0);
        chk({tag, "_ram_waddr"}, 32'(ram_waddr), 32'd0);
        chk({tag, "_ram_raddr"}, 32'(ram_raddr), 32'd0);
        chk({tag, "_ram_wd"}, 32'(ram_wd), 32'd0);
`ifdef ADC_FIFO_OVF_CNT_EN
        chk({tag, "_ovf_cnt"}, 32'(ovf_cnt), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RESETN           = 1'b0;
        sample_in        = '0;
        sample_valid     = 1'b0;
        flush            = 1'b0;
        clr_ovf          = 1'b0;
        out_if.out_ready = 1'b0;
        #1;
        check_reset_values("rst");
        repeat (2) @(posedge CLK);
        #1;
        RESETN = 1'b1;

        // Basic stream: first valid in the 4th cycle of the burst, then one per cycle.
        out_if.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(i < 5, DW'(i + 1), 1'b1);
            @(negedge CLK);
            chk($sformatf("t1_valid_c%0d", i), 32'(out_if.out_valid), 32'((i >= 3) ? 1 : 0));
            tick();
        end
        drain("t1");

        // Stall: 18 buffered, the 19th and 20th drop.
        out_if.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, DW'(12'h100 + i), i < 18);
            tick();
        end
        sample_valid = 1'b0;
        @(negedge CLK);
        chk("t2_level", 32'(level), 32'd16);
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_head", 32'(out_if.out_data), 32'h100);
`ifdef ADC_FIFO_OVF_CNT_EN
        chk("t2_ovf_cnt", 32'(ovf_cnt), 32'd2);
`endif
        tick();
        drain("t2");

        // Flush with a concurrent push; overflow is left alone.
        out_if.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, DW'(12'h180 + i), 1'b1);
            tick();
        end
        drive(1'b1, 12'hABC, 1'b0);
        flush = 1'b1;
        @(negedge CLK);
        chk("t3_level_pre", 32'(level), 32'd8);
        exp_q.delete();
        tick();
        flush        = 1'b0;
        sample_valid = 1'b0;
        @(negedge CLK);
        chk("t3_level", 32'(level), 32'd0);
        chk("t3_out_valid", 32'(out_if.out_valid), 32'd0);
        chk("t3_empty", 32'(empty), 32'd1);
        chk("t3_overflow", 32'(overflow), 32'd1);
        tick();
        drain("t3");

        // clr_ovf racing a drop keeps overflow set; clr_ovf alone clears it.
        out_if.out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, DW'(12'h400 + i), 1'b1);
            tick();
        end
        drive(1'b1, 12'h2FF, 1'b0);
        clr_ovf = 1'b1;
        @(negedge CLK);
        chk("t4_full", 32'(full), 32'd1);
        tick();
        clr_ovf      = 1'b0;
        sample_valid = 1'b0;
        @(negedge CLK);
        chk("t4_ovf_kept", 32'(overflow), 32'd1);
`ifdef ADC_FIFO_OVF_CNT_EN
        chk("t4_ovf_cnt_one", 32'(ovf_cnt), 32'd1);
`endif
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        @(negedge CLK);
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
`ifdef ADC_FIFO_OVF_CNT_EN
        chk("t4_ovf_cnt_clr", 32'(ovf_cnt), 32'd0);
`endif
        tick();
        drain("t4");

        // Random consumer stalls across pointer wrap.
        n = 0;
        for (int i = 0; i < 80; i++) begin
            out_if.out_ready = ($urandom_range(0, 3) != 0);
            drive((i % 2 == 0) && (n < 40), DW'(12'h200 + n), 1'b1);
            if (sample_valid) n++;
            tick();
        end
        sample_valid = 1'b0;
        @(negedge CLK);
        chk("t5_no_drop", 32'(overflow), 32'd0);
        tick();
        drain("t5");

        // Asynchronous reset mid-stream.
        out_if.out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, DW'(12'h300 + i), 1'b1);
            tick();
        end
        sample_valid = 1'b0;
        @(negedge CLK);
        chk("t6_level", 32'(level), 32'd10);
        chk("t6_valid", 32'(out_if.out_valid), 32'd1);
        #2;
        RESETN = 1'b0;
        #1;
        check_reset_values("t6_rst");
        exp_q.delete();
        repeat (2) tick();
        RESETN = 1'b1;
        drive(1'b1, 12'h5A5, 1'b1);
        tick();
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
